// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Multi-cycle control FSM for the TSC 16-bit CPU. Sequences the shared datapath
//   (one ALU, one memory port, PC, IR, register file) through IF/ID/EX/MEM/WB, with
//   configurable fetch/data wait counts and explicit halt and retire reporting.
//
//   Optional feature macro: MEM_READY_HANDSHAKE_EN
//     defined   - adds the mem_ready input; IF and MEM end in the cycle mem_ready=1,
//                 and IF_LATENCY/MEM_LATENCY are ignored.
//     undefined - IF and MEM last exactly IF_LATENCY / MEM_LATENCY cycles.
//
// Ports
//   clk, reset             clock (rising edge), asynchronous active-high reset
//   opcode, func_code      IR[15:12], IR[5:0]
//   mem_ready              memory done (handshake build only)
//   mem_read, mem_write    memory port strobes; i_or_d selects PC(0) / ALUOut(1) address
//   ir_write, mem_to_reg   IR load, write-back from memory data
//   reg_write, reg_dst     register write, destination (0 rt, 1 rd, 2 $2)
//   alu_src_a, alu_src_b   ALU operand selects (A: PC/A latch; B: B latch/1/imm)
//   pc_source, pc_write    PC source (ALU/ALUOut/jump target/A latch), unconditional load
//   pc_write_cond          PC load gated by bcond in the datapath
//   pc_to_reg, wwd, halt   link write-back, output-port write, halted indication
//   inst_done              one-cycle pulse on each instruction's final cycle
//   state                  current FSM state (debug)
module multicycle_controller #(
  parameter int unsigned IF_LATENCY  = 4,
  parameter int unsigned MEM_LATENCY = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic [5:0] func_code,
`ifdef MEM_READY_HANDSHAKE_EN
  input  logic       mem_ready,
`endif
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       ir_write,
  output logic       i_or_d,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] reg_dst,
  output logic       pc_to_reg,
  output logic       wwd,
  output logic       halt,
  output logic       inst_done,
  output logic [2:0] state
);

  // TSC opcode / function encodings
  localparam logic [3:0] OpBlz   = 4'd3;
  localparam logic [3:0] OpAdi   = 4'd4;
  localparam logic [3:0] OpOri   = 4'd5;
  localparam logic [3:0] OpLhi   = 4'd6;
  localparam logic [3:0] OpLwd   = 4'd7;
  localparam logic [3:0] OpSwd   = 4'd8;
  localparam logic [3:0] OpJmp   = 4'd9;
  localparam logic [3:0] OpJal   = 4'd10;
  localparam logic [3:0] OpRtype = 4'd15;
  localparam logic [5:0] FnShr   = 6'd7;
  localparam logic [5:0] FnJpr   = 6'd25;
  localparam logic [5:0] FnJrl   = 6'd26;
  localparam logic [5:0] FnWwd   = 6'd28;
  localparam logic [5:0] FnHlt   = 6'd29;

  typedef enum logic [2:0] {
    StIf     = 3'd0,
    StId     = 3'd1,
    StEx     = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalted = 3'd5
  } state_e;

  state_e state_q;

  // Instruction decode
  logic is_rtype, is_r_alu, is_jpr, is_jrl, is_wwd, is_hlt;
  logic is_branch, is_imm_alu, is_lwd, is_swd, is_jmp, is_jal, is_undef;

  assign is_rtype   = (opcode == OpRtype);
  assign is_r_alu   = is_rtype && (func_code <= FnShr);
  assign is_jpr     = is_rtype && (func_code == FnJpr);
  assign is_jrl     = is_rtype && (func_code == FnJrl);
  assign is_wwd     = is_rtype && (func_code == FnWwd);
  assign is_hlt     = is_rtype && (func_code == FnHlt);
  assign is_branch  = (opcode <= OpBlz);
  assign is_imm_alu = (opcode == OpAdi) || (opcode == OpOri) || (opcode == OpLhi);
  assign is_lwd     = (opcode == OpLwd);
  assign is_swd     = (opcode == OpSwd);
  assign is_jmp     = (opcode == OpJmp);
  assign is_jal     = (opcode == OpJal);
  assign is_undef   = !(is_r_alu || is_jpr || is_jrl || is_wwd || is_hlt || is_branch ||
                        is_imm_alu || is_lwd || is_swd || is_jmp || is_jal);

  // Final cycle of a fetch / data access
  logic if_last, mem_last;

`ifdef MEM_READY_HANDSHAKE_EN
  assign if_last  = mem_ready;
  assign mem_last = mem_ready;
`else
  localparam int unsigned MaxLat  = (IF_LATENCY > MEM_LATENCY) ? IF_LATENCY : MEM_LATENCY;
  localparam int unsigned CntW    = (MaxLat > 1) ? $clog2(MaxLat) : 1;
  localparam logic [CntW-1:0] IfLast  = CntW'(IF_LATENCY - 1);
  localparam logic [CntW-1:0] MemLast = CntW'(MEM_LATENCY - 1);

  logic [CntW-1:0] cnt_q;

  assign if_last  = (cnt_q == IfLast);
  assign mem_last = (cnt_q == MemLast);

  // Counts only while waiting in IF/MEM; any state exit returns it to 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if ((state_q == StIf && !if_last) || (state_q == StMem && !mem_last)) begin
      cnt_q <= cnt_q + 1'b1;
    end else begin
      cnt_q <= '0;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIf;
    end else begin
      unique case (state_q)
        StIf: if (if_last) state_q <= StId;
        StId: begin
          if (is_hlt)                                      state_q <= StHalted;
          else if (is_jal || is_jrl)                       state_q <= StWb;
          else if (is_jmp || is_jpr || is_wwd || is_undef) state_q <= StIf;
          else                                             state_q <= StEx;
        end
        StEx: begin
          if (is_branch)              state_q <= StIf;
          else if (is_lwd || is_swd)  state_q <= StMem;
          else                        state_q <= StWb;
        end
        StMem:    if (mem_last) state_q <= is_lwd ? StWb : StIf;
        StWb:     state_q <= StIf;
        StHalted: state_q <= StHalted;
        default:  state_q <= StIf;
      endcase
    end
  end

  assign state = state_q;

  always_comb begin
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    ir_write      = 1'b0;
    i_or_d        = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    pc_source     = 2'd0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    reg_dst       = 2'd0;
    pc_to_reg     = 1'b0;
    wwd           = 1'b0;
    halt          = 1'b0;
    inst_done     = 1'b0;
    unique case (state_q)
      StIf: begin
        mem_read = 1'b1;
        if (if_last) begin
          // Latch IR and advance PC <- PC + 1 through the ALU
          ir_write  = 1'b1;
          alu_src_b = 2'd1;
          pc_write  = 1'b1;
        end
      end
      StId: begin
        // ALUOut captures PC + imm as the branch target for EX
        alu_src_b = 2'd2;
        if (is_jmp || is_jal) begin
          pc_source = 2'd2;
          pc_write  = 1'b1;
        end
        if (is_jpr || is_jrl) begin
          pc_source = 2'd3;
          pc_write  = 1'b1;
        end
        wwd       = is_wwd;
        inst_done = is_jmp || is_jpr || is_wwd || is_hlt || is_undef;
      end
      StEx: begin
        alu_src_a = 1'b1;
        alu_src_b = (is_imm_alu || is_lwd || is_swd) ? 2'd2 : 2'd0;
        if (is_branch) begin
          pc_source     = 2'd1;
          pc_write_cond = 1'b1;
          inst_done     = 1'b1;
        end
      end
      StMem: begin
        i_or_d    = 1'b1;
        mem_read  = is_lwd;
        mem_write = is_swd;
        inst_done = mem_last && is_swd;
      end
      StWb: begin
        reg_write  = 1'b1;
        inst_done  = 1'b1;
        mem_to_reg = is_lwd;
        if (is_jal || is_jrl) begin
          reg_dst   = 2'd2;
          pc_to_reg = 1'b1;
        end else if (is_rtype) begin
          reg_dst = 2'd1;
        end
      end
      StHalted: halt = 1'b1;
      default: ;
    endcase
  end

endmodule
